// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcodes and the ALUOp codes that the downstream ALU control stage decodes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, driving datapath enables and selects, counting retirements.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
    // Counter wraps naturally at 2^CNT_W.
    retired_d = retired_q + (retire ? CNT_W'(1) : '0);
  end

  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUOp    = ALUOP_ADD;
    unique case (state_q)
      S_FETCH: begin
        // PC increment and IR load must wait for the memory to return data.
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        Branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign retired    = retired_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle bench for multicycle_control; expected per-cycle
// state/controls/counters are queued when driven and popped when sampled.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic        RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUOp;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] retired;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] ret;
    logic        ill;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_ret;
  logic        exp_ill;

  // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,
  //  ALUSrcA,ALUSrcB[1:0],PCSrc[1:0],ALUOp[2:0]} expected in each state.
  function automatic logic [16:0] ctrl_tab(input logic [3:0] s, input logic mr);
    case (s)
      4'd0:  ctrl_tab = {mr, 4'b0010, mr, 4'b0000, 2'b01, 2'b00, 3'b000};
      4'd1:  ctrl_tab = {10'b0000000000, 2'b11, 2'b00, 3'b000};
      4'd2:  ctrl_tab = {10'b0000000001, 2'b10, 2'b00, 3'b000};
      4'd3:  ctrl_tab = {10'b0011000000, 2'b00, 2'b00, 3'b000};
      4'd4:  ctrl_tab = {10'b0000000110, 2'b00, 2'b00, 3'b000};
      4'd5:  ctrl_tab = {10'b0010100000, 2'b00, 2'b00, 3'b000};
      4'd6:  ctrl_tab = {10'b0000000001, 2'b00, 2'b00, 3'b010};
      4'd7:  ctrl_tab = {10'b0000001010, 2'b00, 2'b00, 3'b000};
      4'd8:  ctrl_tab = {10'b0100000001, 2'b00, 2'b01, 3'b001};
      4'd9:  ctrl_tab = {10'b0000000001, 2'b10, 2'b00, 3'b000};
      4'd10: ctrl_tab = {10'b0000000010, 2'b00, 2'b00, 3'b000};
      4'd11: ctrl_tab = {10'b1000000000, 2'b00, 2'b10, 3'b000};
      default: ctrl_tab = 'x;
    endcase
  endfunction

  // One cycle: drive at negedge, sample 1ns later, then let the posedge happen.
  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input string tag);
    exp_t e, g;
    logic [16:0] act;
    @(negedge clk);
    rst_n = r; opcode = op; mem_ready = mr;
    e.st = st; e.ctrl = ctrl_tab(st, mr); e.ret = exp_ret; e.ill = exp_ill; e.tag = tag;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    act = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp};
    tests++;
    assert (state === g.st) else begin
      fails++; $error("FAIL %s state got %0d exp %0d", g.tag, state, g.st);
    end
    tests++;
    assert (act === g.ctrl) else begin
      fails++; $error("FAIL %s ctrl got %b exp %b", g.tag, act, g.ctrl);
    end
    tests++;
    assert (retired === g.ret) else begin
      fails++; $error("FAIL %s retired got %0d exp %0d", g.tag, retired, g.ret);
    end
    tests++;
    assert (illegal_op === g.ill) else begin
      fails++; $error("FAIL %s illegal_op got %b exp %b", g.tag, illegal_op, g.ill);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = 6'b0; mem_ready = 1'b1;
    exp_ret = 0; exp_ill = 1'b0;
    @(posedge clk); @(posedge clk);
    step(0, 6'b100011, 1, 4'd0, "reset");

    // LW: 0,1,2,3,4 then retired 1 in next FETCH
    step(1, 6'b100011, 1, 4'd0, "lw_fetch");
    step(1, 6'b100011, 1, 4'd1, "lw_dec");
    step(1, 6'b100011, 1, 4'd2, "lw_adr");
    step(1, 6'b100011, 1, 4'd3, "lw_rd");
    step(1, 6'b100011, 1, 4'd4, "lw_wb");
    exp_ret = 1;

    // RTYPE with two FETCH wait cycles
    step(1, 6'b000000, 0, 4'd0, "rt_fetch_w0");
    step(1, 6'b000000, 0, 4'd0, "rt_fetch_w1");
    step(1, 6'b000000, 1, 4'd0, "rt_fetch");
    step(1, 6'b000000, 1, 4'd1, "rt_dec");
    step(1, 6'b000000, 1, 4'd6, "rt_exec");
    step(1, 6'b000000, 1, 4'd7, "rt_wb");
    exp_ret = 2;

    // SW with three MEMWR wait cycles; retired moves only on exit
    step(1, 6'b101011, 1, 4'd0, "sw_fetch");
    step(1, 6'b101011, 1, 4'd1, "sw_dec");
    step(1, 6'b101011, 1, 4'd2, "sw_adr");
    step(1, 6'b101011, 0, 4'd5, "sw_wr_w0");
    step(1, 6'b101011, 0, 4'd5, "sw_wr_w1");
    step(1, 6'b101011, 0, 4'd5, "sw_wr_w2");
    step(1, 6'b101011, 1, 4'd5, "sw_wr");
    exp_ret = 3;

    // BEQ then J
    step(1, 6'b000100, 1, 4'd0, "beq_fetch");
    step(1, 6'b000100, 1, 4'd1, "beq_dec");
    step(1, 6'b000100, 1, 4'd8, "beq_br");
    exp_ret = 4;
    step(1, 6'b000010, 1, 4'd0, "j_fetch");
    step(1, 6'b000010, 1, 4'd1, "j_dec");
    step(1, 6'b000010, 1, 4'd11, "j_jump");
    exp_ret = 5;

    // Illegal opcode, then ADDI; sticky flag, only ADDI counted
    step(1, 6'b111111, 1, 4'd0, "ill_fetch");
    step(1, 6'b111111, 1, 4'd1, "ill_dec");
    exp_ill = 1'b1;
    step(1, 6'b001000, 1, 4'd0, "addi_fetch");
    step(1, 6'b001000, 1, 4'd1, "addi_dec");
    step(1, 6'b001000, 1, 4'd9, "addi_ex");
    step(1, 6'b001000, 1, 4'd10, "addi_wb");
    exp_ret = 6;
    step(1, 6'b001000, 0, 4'd0, "post_addi_fetch");

    // Reset asserted while holding in MEMRD
    step(1, 6'b100011, 1, 4'd0, "lw2_fetch");
    step(1, 6'b100011, 1, 4'd1, "lw2_dec");
    step(1, 6'b100011, 1, 4'd2, "lw2_adr");
    step(1, 6'b100011, 0, 4'd3, "lw2_rd_w");
    step(0, 6'b100011, 0, 4'd3, "lw2_rd_rst");
    exp_ret = 0; exp_ill = 1'b0;
    step(1, 6'b100011, 1, 4'd0, "after_rst");
    step(1, 6'b100011, 1, 4'd1, "after_rst_dec");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS main control unit. A Moore-style state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, plus the 3-bit ALUOp consumed by the ALU control stage directly downstream. It sits between the instruction register's opcode field and the datapath, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset synchronous, active-low
- opcode  in  6  instr[31:26] from instruction register
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load if ALU zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext(imm), 11 = signext(imm)<<2
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  out  3  000 ADD, 001 SUB, 010 RTYPE (funct decoded downstream)
- state  out  4  current state (debug)
- illegal_op  out  1  sticky: unsupported opcode decoded
- retired  out  CNT_W  instructions completed since reset

## Operation
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Outputs are decoded from the state register. The only exception: PCWrite and IRWrite in FETCH are gated by mem_ready. Any signal not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00, IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0, else goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD.
  - LW/SW -> MEMADR, RTYPE -> EXEC, BEQ -> BRANCH, ADDI -> ADDIEX, J -> JUMP.
  - Any other opcode -> FETCH and sets illegal_op.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. LW -> MEMRD, SW -> MEMWR. opcode is held stable by the IR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE. -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, Branch=1, PCSrc=01. -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- JUMP: PCWrite=1, PCSrc=10. -> FETCH.
- retired increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, ADDIWB or JUMP, and leaving MEMWR with mem_ready=1.
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes are not counted.
- illegal_op stays 1 until reset. Execution continues with the next fetch.

## Timing
- A sampled rst_n=0 forces state=FETCH, retired=0, illegal_op=0 on that edge, including mid-instruction. An in-flight MEMWR is abandoned.
- Output values while in reset/FETCH: MemRead=1, ALUSrcB=01; IRWrite=PCWrite=mem_ready; everything else 0.
- Cycles per instruction with mem_ready held 1:
  - LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRead/MemWrite stay asserted and the address select stays stable for the whole wait.
- mem_ready is ignored in all other states.
- retired updates on the same edge as the transition into FETCH. It is visible in the first FETCH cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - the 4-bit state enum (FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11);
  - opcode constants;
  - ALUOp constants, which the ALU control stage also uses.
- Single module: next-state logic, state register, output decode, counter. No sub-module.

## Test plan
- Reset then LW (100011), mem_ready=1: states 0,1,2,3,4,0. RegWrite=1 with MemtoReg=1 in MEMWB only; retired 0 -> 1.
- RTYPE with mem_ready=0 for 2 FETCH cycles: FETCH lasts 3 cycles and IRWrite=0 until the third. ALUOp=010 in EXEC; RegDst=1 in ALUWB; total 6 cycles.
- SW with mem_ready low 3 cycles in MEMWR: MemWrite=1, IorD=1 held 4 cycles; retired increments only on exit.
- BEQ then J: BRANCH gives ALUOp=001, Branch=1, PCSrc=01. JUMP gives PCWrite=1, PCSrc=10. retired +2 after 6 cycles.
- Opcode 111111: DECODE -> FETCH, illegal_op=1 and stays 1 across a following ADDI. retired increases by 1 only.
- rst_n=0 asserted in MEMRD: next state FETCH, retired=0, illegal_op=0, MemRead=1 with IorD=0.
